// File: rtl/df_coef_loader_if.sv
// Serial coefficient load bus between the config pins and df_coef_loader.
// The slave modport is the loader; the master modport drives the serial stream.
interface df_coef_loader_if #(
    parameter int NUM_TAPS = 4,
    parameter int COEF_W   = 2
);
    localparam int FRAME_W = NUM_TAPS * COEF_W;

    logic               load_en_i;
    logic               ser_valid_i;
    logic               ser_bit_i;
    logic [FRAME_W-1:0] coef_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    modport master (
        output load_en_i,
        output ser_valid_i,
        output ser_bit_i,
        input  coef_o,
        input  busy_o,
        input  done_o,
        input  err_o
    );

    modport slave (
        input  load_en_i,
        input  ser_valid_i,
        input  ser_bit_i,
        output coef_o,
        output busy_o,
        output done_o,
        output err_o
    );
endinterface

// File: rtl/df_coef_loader.sv
// Serial-in coefficient loader with atomic commit to the filter coefficient bus.
// Optional trailing even-parity bit per frame when DF_COEF_PARITY_EN is defined.
module df_coef_loader #(
    parameter int NUM_TAPS = 4,
    parameter int COEF_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    df_coef_loader_if.slave  bus
);
    localparam int FRAME_W = NUM_TAPS * COEF_W;
`ifdef DF_COEF_PARITY_EN
    localparam int FRAME_LEN = FRAME_W + 1;
`else
    localparam int FRAME_LEN = FRAME_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] coef_q, coef_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [FRAME_W-1:0] shadow_ins_s;
    logic               last_data_s;

`ifdef DF_COEF_PARITY_EN
    // Even parity over data plus parity bit must come out zero.
    function automatic logic parity_ok(input logic [FRAME_W-1:0] data, input logic pbit);
        return ~((^data) ^ pbit);
    endfunction
`endif

    assign last_data_s = (cnt_q == CNT_W'(FRAME_W - 1));

    // Each bit lands directly in its final slot; from a cleared shadow this
    // matches an MSB-first shift, so the first bit ends up at the frame MSB.
    always_comb begin
        shadow_ins_s = shadow_q;
        for (int i = 0; i < FRAME_W; i++) begin
            if (cnt_q == CNT_W'(FRAME_W - 1 - i)) begin
                shadow_ins_s[i] = bus.ser_bit_i;
            end else begin
                shadow_ins_s[i] = shadow_q[i];
            end
        end
    end

    // Next-state and output decode for the load FSM.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        coef_d   = coef_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_en_i) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = {CNT_W{1'b0}};
                    shadow_d = {FRAME_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_valid_i) begin
`ifdef DF_COEF_PARITY_EN
                    if (cnt_q == CNT_W'(FRAME_W)) begin
                        // Parity bit completes the frame even if load_en drops with it.
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_WAIT_END;
                        if (parity_ok(shadow_q, bus.ser_bit_i)) begin
                            coef_d = shadow_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end else if (!bus.load_en_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shadow_d = shadow_ins_s;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
`else
                    if (last_data_s) begin
                        shadow_d = shadow_ins_s;
                        cnt_d    = cnt_q + CNT_W'(1);
                        coef_d   = shadow_ins_s;
                        done_d   = 1'b1;
                        state_d  = ST_WAIT_END;
                    end else if (!bus.load_en_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shadow_d = shadow_ins_s;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
`endif
                end else if (!bus.load_en_i) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_WAIT_END: begin
                if (!bus.load_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_END;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= {FRAME_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            coef_q   <= {FRAME_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            coef_q   <= coef_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.coef_o = coef_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_df_coef_loader.sv
// Directed self-checking bench for df_coef_loader; adapts to DF_COEF_PARITY_EN.
module tb_df_coef_loader;
`ifdef DF_COEF_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    int   err_cnt;
    int   busy_cnt;

    df_coef_loader_if #(.NUM_TAPS(4), .COEF_W(2)) bus ();

    df_coef_loader #(.NUM_TAPS(4), .COEF_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done_o === 1'b1) done_cnt++;
        if (bus.err_o === 1'b1) err_cnt++;
        if (bus.busy_o === 1'b1) busy_cnt++;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.ser_valid_i = 1'b1;
        bus.ser_bit_i   = b;
        tick();
        bus.ser_valid_i = 1'b0;
        bus.ser_bit_i   = 1'b0;
    endtask

    // Sends one frame MSB first, appending the parity bit in the parity build.
    task automatic send_frame(input logic [7:0] d, input bit gaps, input bit drop_last, input logic par_flip);
        logic [NBITS-1:0] fv;
`ifdef DF_COEF_PARITY_EN
        fv = {d, (^d) ^ par_flip};
`else
        fv = d ^ {8{par_flip}};
`endif
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (drop_last && i == 0) bus.load_en_i = 1'b0;
            send_bit(fv[i]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_counts();
        rst_n           = 1'b1;
        bus.load_en_i   = 1'b0;
        bus.ser_valid_i = 1'b0;
        bus.ser_bit_i   = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_coef", 32'(bus.coef_o), 32'h00);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_done", 32'(bus.done_o), 32'h0);
        check("rst_err",  32'(bus.err_o),  32'h0);
        #10 rst_n = 1'b1;
        tick();

        // Valid bits in IDLE are ignored.
        clear_counts();
        send_bit(1'b1);
        send_bit(1'b1);
        check("idle_ignore_coef", 32'(bus.coef_o), 32'h00);
        check("idle_ignore_busy", 32'(busy_cnt), 32'd0);

        // Back-to-back frame 8'hE4.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        check("t1_busy_start", 32'(bus.busy_o), 32'h1);
        send_frame(8'hE4, 1'b0, 1'b0, 1'b0);
        check("t1_coef", 32'(bus.coef_o), 32'hE4);
        check("t1_done_now", 32'(bus.done_o), 32'h1);
        check("t1_busy_end", 32'(bus.busy_o), 32'h0);
        check("t1_busy_cycles", 32'(busy_cnt), 32'(NBITS));
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        tick();
        check("t1_done_pulse", 32'(bus.done_o), 32'h0);
        bus.load_en_i = 1'b0;
        tick();

        // Abort after 5 bits: err pulse, coefficients held.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        for (int i = 7; i >= 3; i--) begin
            logic [7:0] v;
            v = 8'h1B;
            send_bit(v[i]);
        end
        bus.load_en_i = 1'b0;
        tick();
        check("t2_err", 32'(bus.err_o), 32'h1);
        check("t2_done", 32'(bus.done_o), 32'h0);
        check("t2_coef_hold", 32'(bus.coef_o), 32'hE4);
        check("t2_busy", 32'(bus.busy_o), 32'h0);
        tick();
        check("t2_err_pulse", 32'(bus.err_o), 32'h0);

        // Next full frame 8'h1B commits.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        send_frame(8'h1B, 1'b0, 1'b0, 1'b0);
        check("t2b_coef", 32'(bus.coef_o), 32'h1B);
        check("t2b_done_cnt", 32'(done_cnt), 32'd1);
        bus.load_en_i = 1'b0;
        tick();

        // Gapped 8'hE4 then extra valid bits in WAIT_END.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        send_frame(8'hE4, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t3_coef", 32'(bus.coef_o), 32'hE4);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);
        check("t3_err_cnt", 32'(err_cnt), 32'd0);
        check("t3_busy_wait", 32'(bus.busy_o), 32'h0);
        bus.load_en_i = 1'b0;
        tick();

        // Final bit coincides with load_en falling: commit wins.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        send_frame(8'h1B, 1'b0, 1'b1, 1'b0);
        check("t4_done", 32'(bus.done_o), 32'h1);
        check("t4_err", 32'(bus.err_o), 32'h0);
        check("t4_coef", 32'(bus.coef_o), 32'h1B);
        tick();
        check("t4_err_cnt", 32'(err_cnt), 32'd0);

`ifdef DF_COEF_PARITY_EN
        // Good parity commits, bad parity errors and holds.
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        send_frame(8'hE4, 1'b0, 1'b0, 1'b0);
        check("p_good_coef", 32'(bus.coef_o), 32'hE4);
        check("p_good_done", 32'(bus.done_o), 32'h1);
        bus.load_en_i = 1'b0;
        tick();
        clear_counts();
        bus.load_en_i = 1'b1;
        tick();
        send_frame(8'h1B, 1'b0, 1'b0, 1'b1);
        check("p_bad_err", 32'(bus.err_o), 32'h1);
        check("p_bad_done", 32'(done_cnt), 32'd0);
        check("p_bad_coef", 32'(bus.coef_o), 32'hE4);
        check("p_bad_busy", 32'(bus.busy_o), 32'h0);
        bus.load_en_i = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-cycle while shifting.
        bus.load_en_i = 1'b1;
        tick();
        check("t6_busy_pre", 32'(bus.busy_o), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_coef", 32'(bus.coef_o), 32'h00);
        check("t6_busy", 32'(bus.busy_o), 32'h0);
        check("t6_done", 32'(bus.done_o), 32'h0);
        check("t6_err",  32'(bus.err_o),  32'h0);
        bus.load_en_i = 1'b0;
        #10 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/df_coef_loader.md
Name: df_coef_loader

Overview:
- Serial coefficient writer for the digital filter datapath. It shifts a coefficient frame in bit by bit and commits it atomically to the parallel coefficient bus that feeds the per-tap constant multipliers (2-bit coef inputs).
- Committed coefficients never change mid-frame, so the multipliers always see a consistent set.
- Sits between the chip-level serial config pins and the filter core.

Parameters:
- NUM_TAPS, 4, number of filter taps (coefficient slots).
- COEF_W, 2, width of each tap coefficient in bits.
- FRAME_W, NUM_TAPS*COEF_W (derived localparam, not overridable), data bits per frame.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_en_i  input  1  frame envelope; high for the whole frame.
- ser_valid_i  input  1  qualifies ser_bit_i for one clk cycle.
- ser_bit_i  input  1  serial coefficient bit, MSB of frame first.
- coef_o  output  FRAME_W  committed coefficients; tap k = coef_o[k*COEF_W +: COEF_W].
- busy_o  output  1  high while a frame is being shifted (state SHIFT).
- done_o  output  1  one-cycle pulse on successful commit.
- err_o  output  1  one-cycle pulse on aborted or invalid frame.

Behaviour:
- Reset (rst_n low, asynchronous): coef_o=0, busy_o=0, done_o=0, err_o=0, shadow=0, bit counter=0, state=IDLE. A reset mid-frame discards the shadow.
- The shadow register (FRAME_W bits) and the bit counter (clog2(FRAME_W+1) bits) are internal.
- State IDLE:
  - load_en_i high -> SHIFT, counter=0, shadow=0.
  - ser_valid_i in IDLE is ignored.
- State SHIFT (busy_o=1):
  - Each cycle with ser_valid_i=1: shadow <= {shadow[FRAME_W-2:0], ser_bit_i}, counter+1.
  - The first received bit ends up at coef_o[FRAME_W-1], i.e. the tap NUM_TAPS-1 MSB.
  - On the valid bit that brings the counter to FRAME_W, at that same edge: coef_o <= new shadow value, done_o=1 for exactly one cycle, state -> WAIT_END.
  - load_en_i low before FRAME_W bits arrive: err_o=1 for one cycle, coef_o unchanged, -> IDLE.
  - If load_en_i falls in the same cycle as a valid final bit, the bit is accepted and the frame commits (done, not err).
- State WAIT_END (busy_o=0):
  - Extra ser_valid_i pulses are ignored, with no error; coef_o is held.
  - load_en_i low -> IDLE. A new frame requires load_en_i to drop for at least one cycle.
- Output timing:
  - done_o and err_o are registered and mutually exclusive.
  - coef_o changes only on a commit edge.
- Latency: last valid bit sampled at edge N -> coef_o and done_o valid after edge N.
- Gaps of any length between ser_valid_i pulses are allowed.

Optional Feature:
- Macro: DF_COEF_PARITY_EN.
- Defined:
  - A frame is FRAME_W data bits plus one trailing even-parity bit (the XOR of all data bits and the parity bit must be 0). The counter runs to FRAME_W+1.
  - Commit happens only on the parity bit edge, and only if parity is correct.
  - Parity mismatch: err_o pulse, coef_o unchanged, -> WAIT_END.
  - busy_o stays high through the parity bit.
- Undefined: no parity bit, no parity logic; behaviour exactly as above.

Test Plan:
- Reset with rst_n low asynchronously mid-cycle -> coef_o=8'h00, busy_o=0, done_o=0, err_o=0 immediately, without waiting for a clk edge.
- Default params: load_en_i=1, bits 1,1,1,0,0,1,0,0 with ser_valid_i every cycle -> coef_o=8'hE4 (taps 3..0 = 3,2,1,0) and a single done_o pulse after the 8th bit edge; busy_o high for exactly the frame.
- Same frame with random 0-3 cycle gaps in ser_valid_i, then 3 extra valid bits in WAIT_END -> coef_o=8'hE4, a single done_o, no err_o.
- After loading 8'hE4, start a frame and drop load_en_i after 5 bits -> err_o pulse, coef_o stays 8'hE4, state returns to IDLE; a next full frame 8'h1B commits 8'h1B.
- Final bit and load_en_i falling in the same cycle -> commit (done_o=1, err_o=0).
- With DF_COEF_PARITY_EN:
  - Frame 8'hE4 with parity 0 -> commit.
  - Same frame with parity 1 -> err_o pulse, coef_o unchanged.
